// File: rtl/wb_cfg_pkg.sv
// Shared types and helpers for the Wishbone config initiator.
package wb_cfg_pkg;

  localparam int unsigned WB_ADDR_W_DEF = 22;
  localparam int unsigned WB_DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_INIT_REQ,
    ST_INIT_BUS,
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_e;

  // Counter width able to hold values 0..max_val (timeout and init index counters).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_cfg_master_if.sv
// Command/response channel plus Wishbone master signals for wb_cfg_master.
interface wb_cfg_master_if #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 32
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;
  logic          init_done_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, wb_ack_i, wb_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, init_done_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, wb_ack_i, wb_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, init_done_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/wb_cfg_master.sv
// Wishbone initiator: boot-time table fill, then single read/write commands
// with ACK timeout, returned on a valid/ready response channel.
module wb_cfg_master
  import wb_cfg_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH  = WB_ADDR_W_DEF,
  parameter int unsigned WB_DATA_WIDTH  = WB_DATA_W_DEF,
  parameter bit          INIT_EN        = 1'b1,
  parameter int unsigned INIT_COUNT     = 8,
  parameter int unsigned INIT_VALUE     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk_i,
  input logic            rst_i,
  wb_cfg_master_if.master bus
);

  localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned IDX_W = cnt_width(INIT_COUNT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_COUNT - 1);
  localparam logic [WB_DATA_WIDTH-1:0] INIT_WORD = WB_DATA_WIDTH'(INIT_VALUE);
  localparam state_e RST_STATE = INIT_EN ? ST_INIT_REQ : ST_IDLE;

  state_e           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [IDX_W-1:0] init_idx;
  logic             ack_c;
  logic             tmo_c;

  // ACK only counts while a cycle is open; stray ACKs are dropped here.
  assign ack_c = bus.wb_cyc_o && bus.wb_ack_i;
  assign tmo_c = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= RST_STATE;
      tmo_cnt         <= '0;
      init_idx        <= '0;
      bus.cmd_ready_o <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_dat_o   <= '0;
      bus.rsp_err_o   <= 1'b0;
      bus.init_done_o <= 1'b0;
      bus.wb_cyc_o    <= 1'b0;
      bus.wb_stb_o    <= 1'b0;
      bus.wb_we_o     <= 1'b0;
      bus.wb_adr_o    <= '0;
      bus.wb_dat_o    <= '0;
    end else begin
      case (state)
        // CYC is low during this state, giving the slave a gap to re-arm its ACK.
        ST_INIT_REQ: begin
          bus.wb_cyc_o <= 1'b1;
          bus.wb_stb_o <= 1'b1;
          bus.wb_we_o  <= 1'b1;
          bus.wb_adr_o <= WB_ADDR_WIDTH'(init_idx);
          bus.wb_dat_o <= INIT_WORD << init_idx;
          tmo_cnt      <= '0;
          state        <= ST_INIT_BUS;
        end

        // A timed-out init write is simply skipped.
        ST_INIT_BUS: begin
          if (ack_c || tmo_c) begin
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            tmo_cnt      <= '0;
            if (init_idx == IDX_LAST) begin
              bus.init_done_o <= 1'b1;
              bus.cmd_ready_o <= 1'b1;
              state           <= ST_IDLE;
            end else begin
              init_idx <= init_idx + IDX_W'(1);
              state    <= ST_INIT_REQ;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_IDLE: begin
          bus.init_done_o <= 1'b1;
          if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            bus.cmd_ready_o <= 1'b0;
            bus.wb_we_o     <= bus.cmd_we_i;
            bus.wb_adr_o    <= bus.cmd_adr_i;
            bus.wb_dat_o    <= bus.cmd_dat_i;
            state           <= ST_BUS;
          end else begin
            bus.cmd_ready_o <= 1'b1;
          end
        end

        // First BUS cycle opens the Wishbone cycle one edge after the accept.
        ST_BUS: begin
          if (!bus.wb_cyc_o) begin
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            tmo_cnt      <= '0;
          end else if (ack_c) begin
            bus.wb_cyc_o    <= 1'b0;
            bus.wb_stb_o    <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_dat_o   <= bus.wb_we_o ? '0 : bus.wb_dat_i;
            tmo_cnt         <= '0;
            state           <= ST_RESP;
          end else if (tmo_c) begin
            bus.wb_cyc_o    <= 1'b0;
            bus.wb_stb_o    <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_dat_o   <= '0;
            tmo_cnt         <= '0;
            state           <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.cmd_ready_o <= 1'b1;
            state           <= ST_IDLE;
          end
        end

        default: state <= RST_STATE;
      endcase
    end
  end

endmodule
